// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous memory port.
// Each access takes one ACCESS cycle, and a read adds one RDWAIT cycle before its data returns.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // IDLE   | arbitrating, no access in flight
  // ACCESS | mem_en and gnt high, memory samples at end of cycle
  // RDWAIT | mem_rdata valid, routed to owner on the closing edge
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  logic [1:0] state;
  logic       rr_last;  // 0 = M0 won last grant, 1 = M1
  logic       owner;
  logic       any_req;
  logic       pick_m1;

  assign any_req = m0_req | m1_req;
  assign pick_m1 = m1_req & (~m0_req | ((FIXED_PRIO == 0) & ~rr_last));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_last   <= 1'b1;
      owner     <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            mem_en    <= 1'b1;
            mem_write <= pick_m1 ? m1_write : m0_write;
            mem_addr  <= pick_m1 ? m1_addr  : m0_addr;
            mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            m0_gnt    <= ~pick_m1;
            m1_gnt    <= pick_m1;
            owner     <= pick_m1;
            rr_last   <= pick_m1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: state <= mem_write ? S_IDLE : S_RDWAIT;
        S_RDWAIT: begin
          if (owner) begin
            m1_rdata  <= mem_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= mem_rdata;
            m0_rvalid <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
